// File: rtl/fft_bf_sched.sv
// Butterfly scheduler for an in-place radix-2 DIT FFT: walks LOG2N stages, emits address pairs and twiddles.
// Optional bit-reversed load phase is built when FFT_BF_SCHED_BITREV_EN is defined.
module fft_bf_sched #(
  parameter int LOG2N = 4,
  parameter int GAP   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       bf_valid,
  input  logic                       bf_ready,
  output logic [LOG2N-1:0]           addr_a,
  output logic [LOG2N-1:0]           addr_b,
  output logic [LOG2N-2:0]           tw_idx,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       bf_last,
  output logic                       ld_valid,
  output logic [LOG2N-1:0]           ld_addr,
  input  logic                       ld_ready
);

  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [SW-1:0] SLAST    = SW'(LOG2N - 1);
  localparam logic [KW-1:0] KMAX     = '1;
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAPW, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [KW-1:0]   k_q, k_d;
  logic [GW-1:0]   g_q, g_d;
  logic            busy_q, done_q, valid_q, last_q;
  logic [LOG2N-1:0] a_q, b_q;
  logic [KW-1:0]   tw_q;
  logic            go;

  // k with its low s bits cleared, shifted up one, is grp*2*half; OR-ing pos completes addr_a.
  function automatic logic [KW-1:0] pos_mask(input logic [SW-1:0] s);
    return (KW'(1) << s) - KW'(1);
  endfunction

  function automatic logic [LOG2N-1:0] addr_a_of(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [KW-1:0] m;
    m = pos_mask(s);
    return ({1'b0, k & ~m} << 1) | {1'b0, k & m};
  endfunction

  function automatic logic [KW-1:0] tw_of(input logic [SW-1:0] s, input logic [KW-1:0] k);
    return (k & pos_mask(s)) << (SLAST - s);
  endfunction

`ifdef FFT_BF_SCHED_BITREV_EN
  localparam logic [LOG2N-1:0] JMAX = '1;
  logic [LOG2N-1:0] j_q, j_d;
  logic             ldv_q;
  logic [LOG2N-1:0] lda_q;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] j);
    logic [LOG2N-1:0] r;
    for (int unsigned i = 0; i < LOG2N; i++) r[i] = j[LOG2N-1-i];
    return r;
  endfunction
`else
  logic unused_ld;
  assign unused_ld = ld_ready;
`endif

  assign go = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    g_d     = g_q;
`ifdef FFT_BF_SCHED_BITREV_EN
    j_d     = j_q;
`endif
    case (state_q)
`ifdef FFT_BF_SCHED_BITREV_EN
      LOAD: if (ldv_q && ld_ready) begin
        if (j_q == JMAX) begin
          j_d     = '0;
          state_d = RUN;
        end else begin
          j_d = j_q + LOG2N'(1);
        end
      end
`endif
      RUN: if (valid_q && bf_ready) begin
        if (k_q == KMAX) begin
          k_d = '0;
          if (GAP > 0) begin
            state_d = GAPW;
            g_d     = GAP_INIT;
          end else if (s_q == SLAST) begin
            state_d = DONE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      GAPW: begin
        if (g_q == '0) begin
          if (s_q == SLAST) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + SW'(1);
            state_d = RUN;
          end
        end else begin
          g_d = g_q - GW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (go) begin
      s_d = '0;
      k_d = '0;
`ifdef FFT_BF_SCHED_BITREV_EN
      j_d     = '0;
      state_d = LOAD;
`else
      state_d = RUN;
`endif
    end
    if (abort) state_d = IDLE;
  end

  // Output registers load from next-state so the first butterfly is visible the cycle after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      g_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      g_q     <= g_d;
      busy_q  <= (state_d == LOAD) || (state_d == RUN) || (state_d == GAPW);
      done_q  <= (state_d == DONE);
      valid_q <= (state_d == RUN);
      last_q  <= (state_d == RUN) && (s_d == SLAST) && (k_d == KMAX);
      a_q     <= addr_a_of(s_d, k_d);
      b_q     <= addr_a_of(s_d, k_d) | (LOG2N'(1) << s_d);
      tw_q    <= tw_of(s_d, k_d);
    end
  end

`ifdef FFT_BF_SCHED_BITREV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_q   <= '0;
      ldv_q <= 1'b0;
      lda_q <= '0;
    end else begin
      j_q   <= j_d;
      ldv_q <= (state_d == LOAD);
      lda_q <= bitrev(j_d);
    end
  end
  assign ld_valid = ldv_q;
  assign ld_addr  = lda_q;
`else
  assign ld_valid = 1'b0;
  assign ld_addr  = '0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign bf_valid = valid_q;
  assign bf_last  = last_q;
  assign addr_a   = a_q;
  assign addr_b   = b_q;
  assign tw_idx   = tw_q;
  assign stage    = s_q;

endmodule

// File: tb/tb_fft_bf_sched.sv
// Directed, table-driven bench for fft_bf_sched (LOG2N=3/GAP=2 and LOG2N=2/GAP=0 instances).
module tb_fft_bf_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: LOG2N=3, GAP=2
  logic       start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1, ldr_a = 1'b1;
  logic       busy_a, done_a, vld_a, last_a, ldv_a;
  logic [2:0] aa_a, ab_a, lda_a;
  logic [1:0] tw_a, stg_a;

  fft_bf_sched #(.LOG2N(3), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
    .bf_valid(vld_a), .bf_ready(ready_a), .addr_a(aa_a), .addr_b(ab_a), .tw_idx(tw_a),
    .stage(stg_a), .bf_last(last_a), .ld_valid(ldv_a), .ld_addr(lda_a), .ld_ready(ldr_a)
  );

  // Instance B: LOG2N=2, GAP=0
  logic       start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1, ldr_b = 1'b1;
  logic       busy_b, done_b, vld_b, last_b, ldv_b;
  logic [1:0] aa_b, ab_b, lda_b;
  logic [0:0] tw_b, stg_b;

  fft_bf_sched #(.LOG2N(2), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .bf_valid(vld_b), .bf_ready(ready_b), .addr_a(aa_b), .addr_b(ab_b), .tw_idx(tw_b),
    .stage(stg_b), .bf_last(last_b), .ld_valid(ldv_b), .ld_addr(lda_b), .ld_ready(ldr_b)
  );

  typedef struct {
    logic vld;
    int   a;
    int   b;
    int   tw;
    int   stg;
    logic last;
    logic busy;
    logic done;
  } vec_t;

  vec_t tA[1:20];
  vec_t tB[1:6];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse_a;
    start_a = 1'b1;
    next_cyc();
    start_a = 1'b0;
  endtask

  task automatic check_a(input int c, input vec_t e);
    chk("A.valid", c, 32'(vld_a), 32'(e.vld));
    chk("A.busy",  c, 32'(busy_a), 32'(e.busy));
    chk("A.done",  c, 32'(done_a), 32'(e.done));
    chk("A.last",  c, 32'(last_a), 32'(e.last));
    if (e.vld) begin
      chk("A.addr_a", c, 32'(aa_a), e.a);
      chk("A.addr_b", c, 32'(ab_a), e.b);
      chk("A.tw_idx", c, 32'(tw_a), e.tw);
      chk("A.stage",  c, 32'(stg_a), e.stg);
    end
  endtask

  initial begin
    vec_t g, z;
    int done_cyc, n_done;
    g = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    z = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tA[1]  = '{1'b1, 0, 1, 0, 0, 1'b0, 1'b1, 1'b0};
    tA[2]  = '{1'b1, 2, 3, 0, 0, 1'b0, 1'b1, 1'b0};
    tA[3]  = '{1'b1, 4, 5, 0, 0, 1'b0, 1'b1, 1'b0};
    tA[4]  = '{1'b1, 6, 7, 0, 0, 1'b0, 1'b1, 1'b0};
    tA[5]  = g;  tA[6] = g;
    tA[7]  = '{1'b1, 0, 2, 0, 1, 1'b0, 1'b1, 1'b0};
    tA[8]  = '{1'b1, 1, 3, 2, 1, 1'b0, 1'b1, 1'b0};
    tA[9]  = '{1'b1, 4, 6, 0, 1, 1'b0, 1'b1, 1'b0};
    tA[10] = '{1'b1, 5, 7, 2, 1, 1'b0, 1'b1, 1'b0};
    tA[11] = g;  tA[12] = g;
    tA[13] = '{1'b1, 0, 4, 0, 2, 1'b0, 1'b1, 1'b0};
    tA[14] = '{1'b1, 1, 5, 1, 2, 1'b0, 1'b1, 1'b0};
    tA[15] = '{1'b1, 2, 6, 2, 2, 1'b0, 1'b1, 1'b0};
    tA[16] = '{1'b1, 3, 7, 3, 2, 1'b1, 1'b1, 1'b0};
    tA[17] = g;  tA[18] = g;
    tA[19] = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    tA[20] = z;

    tB[1] = '{1'b1, 0, 1, 0, 0, 1'b0, 1'b1, 1'b0};
    tB[2] = '{1'b1, 2, 3, 0, 0, 1'b0, 1'b1, 1'b0};
    tB[3] = '{1'b1, 0, 2, 0, 1, 1'b0, 1'b1, 1'b0};
    tB[4] = '{1'b1, 1, 3, 1, 1, 1'b1, 1'b1, 1'b0};
    tB[5] = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    tB[6] = z;

    // Reset state
    #2 rst = 1'b1;
    next_cyc();
    next_cyc();
    chk("rst.busy", 0, 32'(busy_a), 0);
    chk("rst.done", 0, 32'(done_a), 0);
    chk("rst.valid", 0, 32'(vld_a), 0);
    chk("rst.last", 0, 32'(last_a), 0);
    chk("rst.ld_valid", 0, 32'(ldv_a), 0);
    chk("rst.ld_addr", 0, 32'(lda_a), 0);
    chk("rst.addrs", 0, {aa_a, ab_a, tw_a, stg_a}, 0);
    rst = 1'b0;
    next_cyc();

`ifdef FFT_BF_SCHED_BITREV_EN
    begin
      int br[8];
      br = '{0, 4, 2, 6, 1, 5, 3, 7};
      start_pulse_a();
      for (int c = 1; c <= 8; c++) begin
        chk("LD.valid", c, 32'(ldv_a), 1);
        chk("LD.addr", c, 32'(lda_a), br[c-1]);
        chk("LD.busy", c, 32'(busy_a), 1);
        chk("LD.bf_valid", c, 32'(vld_a), 0);
        next_cyc();
      end
      chk("LD.after_valid", 9, 32'(ldv_a), 0);
      chk("LD.first_bf", 9, {29'd0, vld_a, 2'd0}, 32'd4);
      chk("LD.first_pair", 9, {26'd0, aa_a, ab_a}, {26'd0, 3'd0, 3'd1});
    end
`else
    // Full sequence, with start pulses while busy that must be ignored
    start_pulse_a();
    for (int c = 1; c <= 20; c++) begin
      start_a = (c == 3 || c == 12);
      chk("A.ld_valid", c, 32'(ldv_a), 0);
      check_a(c, tA[c]);
      next_cyc();
    end
    start_a = 1'b0;

    // Backpressure on (1,3) in stage 1 for cycles 8..10
    start_pulse_a();
    done_cyc = -1;
    n_done = 0;
    for (int c = 1; c <= 25; c++) begin
      ready_a = !(c >= 8 && c <= 10);
      if (c >= 8 && c <= 11) begin
        chk("BP.valid", c, 32'(vld_a), 1);
        chk("BP.pair", c, {26'd0, aa_a, ab_a}, {26'd0, 3'd1, 3'd3});
        chk("BP.tw", c, 32'(tw_a), 2);
      end
      if (done_a) begin
        n_done++;
        done_cyc = c;
      end
      next_cyc();
    end
    ready_a = 1'b1;
    chk("BP.done_cycle", 25, done_cyc, 22);
    chk("BP.done_count", 25, n_done, 1);

    // Abort sampled at the end of cycle 8
    start_pulse_a();
    for (int c = 1; c <= 20; c++) begin
      abort_a = (c == 8);
      if (c == 8) chk("AB.pre_valid", c, 32'(vld_a), 1);
      if (c >= 9) begin
        chk("AB.valid", c, 32'(vld_a), 0);
        chk("AB.busy", c, 32'(busy_a), 0);
        chk("AB.done", c, 32'(done_a), 0);
      end
      next_cyc();
    end
    abort_a = 1'b0;
    start_pulse_a();
    check_a(1, tA[1]);

    // Mid-run reset clears outputs in the same cycle
    next_cyc();
    next_cyc();
    chk("RR.pre_pair", 3, {26'd0, aa_a, ab_a}, {26'd0, 3'd4, 3'd5});
    rst = 1'b1;
    #1;
    chk("RR.busy", 3, 32'(busy_a), 0);
    chk("RR.valid", 3, 32'(vld_a), 0);
    chk("RR.outs", 3, {last_a, done_a, aa_a, ab_a, tw_a, stg_a}, 0);
    #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      next_cyc();
      chk("RR.stay_idle", c, {busy_a, vld_a, done_a}, 0);
    end

    // GAP=0, LOG2N=2
    start_b = 1'b1;
    next_cyc();
    start_b = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("B.valid", c, 32'(vld_b), 32'(tB[c].vld));
      chk("B.busy", c, 32'(busy_b), 32'(tB[c].busy));
      chk("B.done", c, 32'(done_b), 32'(tB[c].done));
      chk("B.last", c, 32'(last_b), 32'(tB[c].last));
      if (tB[c].vld) begin
        chk("B.addr_a", c, 32'(aa_b), tB[c].a);
        chk("B.addr_b", c, 32'(ab_b), tB[c].b);
        chk("B.tw_idx", c, 32'(tw_b), tB[c].tw);
        chk("B.stage", c, 32'(stg_b), tB[c].stg);
      end
      next_cyc();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bf_sched.md
# fft_bf_sched

Butterfly scheduler for the in-place radix-2 decimation-in-time FFT datapath. After a `start` pulse it walks all LOG2N stages and emits one butterfly per accepted handshake: sample-RAM address pair, twiddle index and stage number. It inserts drain gaps between stages so the datapath pipeline can write back, then signals completion. It sits between the host-facing byte interface and the shared butterfly/multiplier datapath, which it owns exclusively while busy.

## Interface
- `LOG2N`, 4: log2 of FFT length N; legal range 2..10.
- `GAP`, 3: idle cycles inserted after the last butterfly of every stage, including the final one; 0 is legal.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a transform; sampled only while `busy`=0.
- `abort` in 1: synchronous; returns the block to IDLE, no `done`.
- `busy` out 1: high from the cycle after an accepted `start` until the `done` cycle, exclusive.
- `done` out 1: one-cycle pulse at transform completion.
- `bf_valid` out 1: butterfly request to the datapath.
- `bf_ready` in 1: datapath accepts; a handshake occurs when `bf_valid` & `bf_ready`.
- `addr_a`, `addr_b` out LOG2N: butterfly operand addresses.
- `tw_idx` out LOG2N-1: twiddle ROM index.
- `stage` out clog2(LOG2N): current stage number.
- `bf_last` out 1: high with the final butterfly of the final stage.
- `ld_valid` out 1, `ld_addr` out LOG2N, `ld_ready` in 1: bit-reversed load port (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, GAPW, DONE.
- IDLE → RUN on `start` (→ LOAD when the macro is defined).
- RUN: counters `s` (stage) and `k` (butterfly, 0..N/2-1). half = 1<<s, pos = k & (half-1), grp = k >> s.
- `addr_a` = grp·2·half + pos. `addr_b` = `addr_a` + half. `tw_idx` = pos << (LOG2N-1-s). All values are exact, with no wrap.
- Each handshake advances `k`. On the handshake with k = N/2-1, `k` resets to 0 and the block enters GAPW for GAP cycles. With GAP=0 it goes directly to the next stage, or to DONE after the final stage.
- GAPW exit: `s`+1 → RUN. After the final stage → DONE.
- DONE lasts one cycle, then returns to IDLE. `start` seen in DONE is accepted, giving DONE → RUN directly.
- `start` while `busy`=1 is ignored.
- `abort` has priority over all transitions. It has no effect in IDLE, and suppresses `done` when it arrives in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `busy`, `done`, `bf_valid`, `ld_valid`, `bf_last` = 0; `addr_a`, `addr_b`, `tw_idx`, `stage`, `ld_addr` = 0; state = IDLE.
- `start` sampled at edge t gives `bf_valid`=1 with the first butterfly in cycle t+1. Without the macro, `busy`=1 from t+1.
- While `bf_valid` & !`bf_ready`, all `bf_*`, `addr_*`, `tw_idx` and `stage` outputs hold stable.
- The next butterfly appears in the cycle after a handshake, so sustained throughput is 1 per cycle.
- `bf_valid`=0 throughout GAPW, DONE and IDLE.
- With `bf_ready` tied high, busy cycles = LOG2N·(N/2 + GAP). `done` appears in the cycle after the last busy cycle.
- `abort` at edge t: all valids and `busy` are low in cycle t+1.
- Reset asserted mid-transform clears state immediately. Operation resumes only after a new `start`.

## Configuration
- `FFT_BF_SCHED_BITREV_EN` defined:
  - `start` enters LOAD, with `busy`=1.
  - LOAD emits `ld_valid`=1 and `ld_addr` = bit-reverse(j) for j = 0..N-1, advancing j on each `ld_valid` & `ld_ready`, with the same hold rules as the butterfly port.
  - After the N-th handshake the block enters RUN with no gap.
- Not defined:
  - The LOAD state is not built.
  - `ld_valid` and `ld_addr` are tied to 0 and `ld_ready` is ignored.
  - `start` goes directly to RUN.

## Test plan
- Sequence check, LOG2N=3, GAP=2, `bf_ready`=1, `start` at cycle 0:
  - Stage 0: pairs (0,1) (2,3) (4,5) (6,7), tw 0 0 0 0, in cycles 1-4.
  - Stage 1: pairs (0,2) (1,3) (4,6) (5,7), tw 0 2 0 2, in cycles 7-10.
  - Stage 2: pairs (0,4) (1,5) (2,6) (3,7), tw 0 1 2 3, in cycles 13-16.
  - `bf_last` high in cycle 16; `done` pulses in cycle 19.
- Backpressure, same setup with `bf_ready` low for 3 cycles during (1,3) in stage 1 → outputs hold (1,3), tw 2; `done` is 3 cycles late (cycle 22).
- GAP=0, LOG2N=2 → 4 consecutive valid cycles: (0,1) (2,3) (0,2) (1,3) with tw 0 0 0 1; `done` pulses in cycle 5.
- `abort` in cycle 8 of the first scenario → `bf_valid` and `busy` are 0 from cycle 9 and no `done` follows. A new `start` restarts at (0,1).
- `start` pulses while `busy` are ignored. `rst` pulsed mid-run → all outputs are 0 in the same cycle.
- With `FFT_BF_SCHED_BITREV_EN`, LOG2N=3 → `ld_addr` sequence 0 4 2 6 1 5 3 7, then (0,1) appears in the cycle after the last load handshake.
